// File: rtl/xnor_popcount_neuron_if.sv
// xnor_popcount_neuron_if: beat input stream and result output stream of one neuron lane
interface xnor_popcount_neuron_if #(
  parameter int CHUNK_W = 64,
  parameter int OUT_W   = 19
);
  logic                    in_valid;
  logic                    in_ready;
  logic [CHUNK_W-1:0]      in_act;
  logic [CHUNK_W-1:0]      in_wt;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [OUT_W-1:0] out_sum;
  logic                    out_bit;
  modport master (
    output in_valid, in_act, in_wt, out_ready,
    input  in_ready, out_valid, out_sum, out_bit
  );
  modport slave (
    input  in_valid, in_act, in_wt, out_ready,
    output in_ready, out_valid, out_sum, out_bit
  );
endinterface

// File: rtl/xnor_popcount_neuron.sv
// xnor_popcount_neuron: sequential XNOR-popcount binary-neuron pre-activation with binarized output
module xnor_popcount_neuron #(
  parameter int IN_BITS = 784,
  parameter int CHUNK_W = 64,
  parameter int OUT_W   = 19
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic signed [OUT_W-1:0] thresh,
  xnor_popcount_neuron_if.slave   s
);
  localparam int NUM_CHUNKS = (IN_BITS + CHUNK_W - 1) / CHUNK_W;
  localparam int LAST_BITS  = IN_BITS - (NUM_CHUNKS - 1) * CHUNK_W;
  localparam int ACC_W      = $clog2(IN_BITS + 1);
  localparam int PC_W       = $clog2(CHUNK_W + 1);
  localparam int CNT_W      = NUM_CHUNKS > 1 ? $clog2(NUM_CHUNKS) : 1;
  localparam logic [CHUNK_W-1:0] LAST_MASK = {CHUNK_W{1'b1}} >> (CHUNK_W - LAST_BITS);
  localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(NUM_CHUNKS - 1);

  if (OUT_W < ACC_W + 1) begin : g_width_check
    $error("OUT_W too narrow for IN_BITS");
  end

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t                  state;
  logic [CNT_W-1:0]        cnt;
  logic [ACC_W-1:0]        acc;
  logic signed [OUT_W-1:0] thresh_q;
  logic [CHUNK_W-1:0]      match;
  logic [PC_W-1:0]         pc;
  logic [ACC_W-1:0]        acc_next;
  logic signed [OUT_W-1:0] sum_next;
  logic signed [OUT_W-1:0] thr;
  logic                    last;

  // matches in the current beat; padding bits of the final chunk are masked off
  always_comb begin
    last  = cnt == CNT_LAST;
    match = ~(s.in_act ^ s.in_wt) & (last ? LAST_MASK : {CHUNK_W{1'b1}});
    pc    = '0;
    for (int i = 0; i < CHUNK_W; i++) pc = pc + PC_W'(match[i]);
    acc_next = acc + ACC_W'(pc);
    sum_next = OUT_W'({acc_next, 1'b0}) - OUT_W'(IN_BITS);
    thr      = cnt == '0 ? thresh : thresh_q;
  end

  // control FSM with registered handshakes, accumulator and held result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      acc         <= '0;
      thresh_q    <= '0;
      s.in_ready  <= 1'b0;
      s.out_valid <= 1'b0;
      s.out_sum   <= '0;
      s.out_bit   <= 1'b0;
    end else if (clr && state != IDLE) begin
      state       <= ACCUM;
      cnt         <= '0;
      acc         <= '0;
      s.in_ready  <= 1'b1;
      s.out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state      <= ACCUM;
          s.in_ready <= 1'b1;
        end
        ACCUM: if (s.in_valid) begin
          if (cnt == '0) thresh_q <= thresh;
          if (last) begin
            s.out_sum   <= sum_next;
            s.out_bit   <= sum_next >= thr;
            s.out_valid <= 1'b1;
            s.in_ready  <= 1'b0;
            state       <= DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
            acc <= acc_next;
          end
        end
        DONE: if (s.out_ready) begin
          s.out_valid <= 1'b0;
          s.in_ready  <= 1'b1;
          cnt         <= '0;
          acc         <= '0;
          state       <= ACCUM;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_xnor_popcount_neuron.sv
// tb_xnor_popcount_neuron: directed vectors with a scoreboard-driven result monitor
module tb_xnor_popcount_neuron;
  typedef struct packed {
    logic signed [18:0] s;
    logic               b;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               clr;
  logic signed [18:0] thresh;
  int                 total = 0;
  int                 bad = 0;
  exp_t               sb[$];

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  xnor_popcount_neuron_if #(.CHUNK_W(64), .OUT_W(19)) ifc ();

  xnor_popcount_neuron #(.IN_BITS(784), .CHUNK_W(64), .OUT_W(19)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .thresh(thresh),
    .s     (ifc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  // result monitor: one pop per output handshake
  initial forever begin
    @(negedge clk);
    if (rst_n && ifc.out_valid && ifc.out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_result", 32'(ifc.out_sum), 32'hDEAD);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("out_sum", 32'(ifc.out_sum), 32'(e.s));
        chk("out_bit", 32'(ifc.out_bit), 32'(e.b));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [63:0] a, input logic [63:0] w);
    int n = 0;
    ifc.in_valid = 1'b1;
    ifc.in_act   = a;
    ifc.in_wt    = w;
    while (!ifc.in_ready && n < 50) begin
      tick();
      n++;
    end
    if (!ifc.in_ready) chk("beat_timeout", 32'(ifc.in_ready), 32'd1);
    tick();
    ifc.in_valid = 1'b0;
    ifc.in_act   = $urandom;
  endtask

  task automatic send_vector(input logic [63:0] ab, input logic [63:0] wb,
                             input logic [63:0] al, input logic [63:0] wl,
                             input logic signed [18:0] thr,
                             input logic signed [18:0] es, input logic eb, input bit gap);
    sb.push_back('{s: es, b: eb});
    thresh = thr;
    for (int c = 0; c < 13; c++) begin
      send_beat(c == 12 ? al : ab, c == 12 ? wl : wb);
      thresh = 19'sd500;
      if (gap && c % 3 == 0 && c != 12) tick();
    end
  endtask

  task automatic drain();
    for (int n = 0; n < 30 && sb.size() != 0; n++) tick();
    chk("drain", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    clr = 1'b0;
    thresh = '0;
    ifc.in_valid = 1'b0;
    ifc.in_act = '0;
    ifc.in_wt = '0;
    ifc.out_ready = 1'b1;
    tick();
    tick();
    chk("rst_in_ready", 32'(ifc.in_ready), 32'd0);
    chk("rst_out_valid", 32'(ifc.out_valid), 32'd0);
    chk("rst_out_sum", 32'(ifc.out_sum), 32'd0);
    chk("rst_out_bit", 32'(ifc.out_bit), 32'd0);
    rst_n = 1'b1;

    // all match: +784 visible right after the 13th beat
    send_vector(ONES, ONES, ONES, ONES, 19'sd0, 19'sd784, 1'b1, 1'b0);
    chk("t1_latency_valid", 32'(ifc.out_valid), 32'd1);
    chk("t1_latency_ready", 32'(ifc.in_ready), 32'd0);
    drain();
    // all mismatch: -784
    send_vector(ONES, '0, ONES, '0, 19'sd0, -19'sd784, 1'b0, 1'b0);
    drain();
    // padding bits of last chunk disagree but are masked
    send_vector('0, '0, 64'hFFFF_FFFF_FFFF_0000, '0, 19'sd0, 19'sd784, 1'b1, 1'b1);
    drain();
    // 384 matches -> -16; threshold boundary
    send_vector(64'hFFFF_FFFF_0000_0000, ONES, 64'hFFFF_FFFF_0000_0000, ONES,
                19'sd0, -19'sd16, 1'b0, 1'b0);
    send_vector(64'hFFFF_FFFF_0000_0000, ONES, 64'hFFFF_FFFF_0000_0000, ONES,
                -19'sd16, -19'sd16, 1'b1, 1'b1);
    drain();
    // 400 matches -> +16
    send_vector(64'h0000_0000_FFFF_FFFF, ONES, 64'h0000_0000_FFFF_FFFF, ONES,
                19'sd0, 19'sd16, 1'b1, 1'b0);
    send_vector(64'h0000_0000_FFFF_FFFF, ONES, 64'h0000_0000_FFFF_FFFF, ONES,
                19'sd17, 19'sd16, 1'b0, 1'b1);
    send_vector(64'h0000_0000_FFFF_FFFF, ONES, 64'h0000_0000_FFFF_FFFF, ONES,
                19'sd16, 19'sd16, 1'b1, 1'b0);
    drain();

    // downstream stall holds the result
    ifc.out_ready = 1'b0;
    send_vector(ONES, ONES, ONES, ONES, 19'sd0, 19'sd784, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("stall_valid", 32'(ifc.out_valid), 32'd1);
      chk("stall_in_ready", 32'(ifc.in_ready), 32'd0);
      chk("stall_sum", 32'(ifc.out_sum), 32'(19'sd784));
    end
    ifc.out_ready = 1'b1;
    tick();
    chk("release_valid", 32'(ifc.out_valid), 32'd0);
    chk("release_in_ready", 32'(ifc.in_ready), 32'd1);
    drain();

    // asynchronous reset mid-vector
    for (int c = 0; c < 5; c++) send_beat(ONES, '0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", 32'(ifc.in_ready), 32'd0);
    chk("mid_rst_out_sum", 32'(ifc.out_sum), 32'd0);
    chk("mid_rst_out_bit", 32'(ifc.out_bit), 32'd0);
    chk("mid_rst_out_valid", 32'(ifc.out_valid), 32'd0);
    tick();
    rst_n = 1'b1;
    send_vector(ONES, ONES, ONES, ONES, 19'sd0, 19'sd784, 1'b1, 1'b0);
    chk("post_rst_latency", 32'(ifc.out_valid), 32'd1);
    drain();

    // clr after 7 beats, with a same-cycle beat that must be dropped
    for (int c = 0; c < 7; c++) send_beat(ONES, '0);
    clr = 1'b1;
    ifc.in_valid = 1'b1;
    ifc.in_act = ONES;
    ifc.in_wt = '0;
    tick();
    clr = 1'b0;
    ifc.in_valid = 1'b0;
    chk("clr_out_valid", 32'(ifc.out_valid), 32'd0);
    chk("clr_in_ready", 32'(ifc.in_ready), 32'd1);
    send_vector(ONES, ONES, ONES, ONES, 19'sd0, 19'sd784, 1'b1, 1'b0);
    chk("post_clr_latency", 32'(ifc.out_valid), 32'd1);
    drain();

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1);
  end
endmodule
